// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencing controller for the 3-stage RV32I core.
// Owns the s2/s3 instruction registers, injects NOP bubbles on reset fill and
// taken control flow, freezes the pipe while data memory is busy, and drives
// the operand-forwarding and regfile write-through selects.
module pipeline_ctrl #(
  parameter int unsigned FILL_CYCLES = 1,
  parameter logic [31:0] NOP         = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_s1,
  input  logic        redirect_s2,
  input  logic        dmem_ready,
  output logic [31:0] instruction_s2,
  output logic [31:0] instruction_s3,
  output logic        pc_stall,
  output logic        pc_redirect,
  output logic [1:0]  rs1_sel,
  output logic [1:0]  rs2_sel,
  output logic        rf_bypass1,
  output logic        rf_bypass2,
  output logic        s3_wen,
  output logic [31:0] bubble_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  localparam logic [1:0] SEL_RF = 2'b10;  // regfile / s2 pipeline register
  localparam logic [1:0] SEL_WB = 2'b01;  // s3 writeback data

  localparam logic [7:0] FILL_LOAD = 8'(FILL_CYCLES - 1);

  typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_MEM_WAIT} state_t;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic writes_rd(input logic [31:0] i);
    logic hit;
    case (i[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
      OP_RTYPE, OP_ITYPE, OP_CSR: hit = 1'b1;
      default:                    hit = 1'b0;
    endcase
    return hit && (i[11:7] != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [31:0] i);
    logic hit;
    case (i[6:0])
      OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_RTYPE, OP_ITYPE: hit = 1'b1;
      OP_CSR:             hit = (i[14:12] == 3'b001);  // csrrw only; csrrwi carries a uimm
      default:            hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic uses_rs2(input logic [31:0] i);
    return (i[6:0] == OP_BRANCH) || (i[6:0] == OP_STORE) || (i[6:0] == OP_RTYPE);
  endfunction

  function automatic logic is_mem(input logic [31:0] i);
    return (i[6:0] == OP_LOAD) || (i[6:0] == OP_STORE);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [7:0]  r_fill_cnt;
  logic [31:0] r_s2;
  logic [31:0] r_s3;
  logic [31:0] r_bubble_cnt;

  state_t      w_state_nxt;
  logic [7:0]  w_fill_cnt_nxt;
  logic [31:0] w_s2_nxt;
  logic [31:0] w_s3_nxt;
  logic        w_mem_hold;
  logic        w_stall;

  // Funct7 and rd of the s1 slot are not needed for any s1-side decision.
  logic w_unused_s1_bits;
  assign w_unused_s1_bits = &{1'b0, instruction_s1[31:25], instruction_s1[11:7]};

  assign w_mem_hold = is_mem(r_s3) && !dmem_ready;
  assign w_stall    = (r_state == ST_FILL) || w_mem_hold;

  // Next-state and next-instruction selection.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_fill_cnt_nxt = r_fill_cnt;
    w_s2_nxt       = r_s2;
    w_s3_nxt       = r_s3;
    case (r_state)
      ST_FILL: begin
        w_s3_nxt = r_s2;
        w_s2_nxt = NOP;
        if (r_fill_cnt == 8'd0) w_state_nxt    = ST_RUN;
        else                    w_fill_cnt_nxt = r_fill_cnt - 8'd1;
      end
      ST_RUN: begin
        if (w_mem_hold) begin
          w_state_nxt = ST_MEM_WAIT;
        end else begin
          w_s3_nxt = r_s2;
          w_s2_nxt = redirect_s2 ? NOP : instruction_s1;
        end
      end
      ST_MEM_WAIT: begin
        // The release cycle behaves exactly like a RUN cycle.
        if (dmem_ready) begin
          w_state_nxt = ST_RUN;
          w_s3_nxt    = r_s2;
          w_s2_nxt    = redirect_s2 ? NOP : instruction_s1;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // State, instruction registers and bubble counter with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state      <= ST_FILL;
      r_fill_cnt   <= FILL_LOAD;
      r_s2         <= NOP;
      r_s3         <= NOP;
      r_bubble_cnt <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_fill_cnt   <= w_fill_cnt_nxt;
      r_s2         <= w_s2_nxt;
      r_s3         <= w_s3_nxt;
      r_bubble_cnt <= r_bubble_cnt + {31'd0, w_stall || redirect_s2};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign instruction_s2 = r_s2;
  assign instruction_s3 = r_s3;
  assign bubble_cnt     = r_bubble_cnt;

  assign pc_stall    = w_stall;
  assign pc_redirect = redirect_s2 && !w_stall && !rst;

  // A stalled load writes only on its ready cycle; a reset kills it outright.
  assign s3_wen = writes_rd(r_s3) && !w_mem_hold && !rst;

  assign rs1_sel = (writes_rd(r_s3) && uses_rs1(r_s2) && (r_s2[19:15] == r_s3[11:7]))
                   ? SEL_WB : SEL_RF;
  assign rs2_sel = (writes_rd(r_s3) && uses_rs2(r_s2) && (r_s2[24:20] == r_s3[11:7]))
                   ? SEL_WB : SEL_RF;

  assign rf_bypass1 = writes_rd(r_s3) && uses_rs1(instruction_s1)
                      && (instruction_s1[19:15] == r_s3[11:7]);
  assign rf_bypass2 = writes_rd(r_s3) && uses_rs2(instruction_s1)
                      && (instruction_s1[24:20] == r_s3[11:7]);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed test-plan sequences followed by random
// traffic. A reference model of the pipeline pushes expected outputs into a
// queue; a negedge monitor pops and compares them against the DUT.
module tb_pipeline_ctrl;

  localparam int unsigned FILL = 1;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [6:0] OPS [11] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                      OP_LOAD, OP_STORE, OP_ITYPE, OP_RTYPE, OP_CSR, OP_FENCE};
  localparam logic [2:0] CSR_F3 [3] = '{3'b001, 3'b101, 3'b010};

  // Directed encodings
  localparam logic [31:0] ADDI_X5_7   = 32'h0070_0293;  // addi x5,x0,7
  localparam logic [31:0] ADD_X6_X5   = 32'h0052_8333;  // add  x6,x5,x5
  localparam logic [31:0] ADD_X6_X0   = 32'h0000_0333;  // add  x6,x0,x0
  localparam logic [31:0] ADDI_X0_1   = 32'h0010_0013;  // addi x0,x0,1
  localparam logic [31:0] BEQ_X1_X2   = 32'h0020_8463;  // beq  x1,x2,+8
  localparam logic [31:0] LW_X7       = 32'h0000_A383;  // lw   x7,0(x1)
  localparam logic [31:0] ADD_X8_X7   = 32'h0003_8433;  // add  x8,x7,x0
  localparam logic [31:0] SW_X2       = 32'h0020_A023;  // sw   x2,0(x1)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction_s1 = NOP;
  logic        redirect_s2 = 1'b0;
  logic        dmem_ready = 1'b1;
  logic [31:0] instruction_s2, instruction_s3, bubble_cnt;
  logic        pc_stall, pc_redirect, rf_bypass1, rf_bypass2, s3_wen;
  logic [1:0]  rs1_sel, rs2_sel;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FILL_CYCLES(FILL), .NOP(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .instruction_s1 (instruction_s1),
    .redirect_s2    (redirect_s2),
    .dmem_ready     (dmem_ready),
    .instruction_s2 (instruction_s2),
    .instruction_s3 (instruction_s3),
    .pc_stall       (pc_stall),
    .pc_redirect    (pc_redirect),
    .rs1_sel        (rs1_sel),
    .rs2_sel        (rs2_sel),
    .rf_bypass1     (rf_bypass1),
    .rf_bypass2     (rf_bypass2),
    .s3_wen         (s3_wen),
    .bubble_cnt     (bubble_cnt)
  );

  typedef struct {
    logic [31:0] s2;
    logic [31:0] s3;
    logic [31:0] bub;
    logic        wen;
    logic        stall;
    logic        redir;
    logic [1:0]  sel1;
    logic [1:0]  sel2;
    logic        byp1;
    logic        byp2;
    bit          comb;   // compare the combinational selects (not during reset)
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: architectural view of the two stage slots
  logic [31:0] m_s2, m_s3, m_bub;
  int          m_fill_left;
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Instruction classification straight from the ISA rules
  function automatic bit m_writes(input logic [31:0] i);
    return (i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
                           OP_RTYPE, OP_ITYPE, OP_CSR}) && (i[11:7] != 5'd0);
  endfunction

  function automatic bit m_rs1(input logic [31:0] i);
    if (i[6:0] == OP_CSR) return i[14:12] == 3'b001;
    return i[6:0] inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE};
  endfunction

  function automatic bit m_rs2(input logic [31:0] i);
    return i[6:0] inside {OP_BRANCH, OP_STORE, OP_RTYPE};
  endfunction

  function automatic bit m_mem(input logic [31:0] i);
    return i[6:0] inside {OP_LOAD, OP_STORE};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom();
    i[6:0]   = OPS[$urandom_range(10, 0)];
    i[11:7]  = 5'($urandom_range(3, 0));
    i[19:15] = 5'($urandom_range(3, 0));
    i[24:20] = 5'($urandom_range(3, 0));
    if (i[6:0] == OP_CSR) i[14:12] = CSR_F3[$urandom_range(2, 0)];
    return i;
  endfunction

  task automatic push_expect(input logic [31:0] ins, input bit redir, input bit ready,
                             input bit rs);
    exp_t e;
    bit   hold;
    bit   stall;
    bit   dep_wr;
    hold   = m_mem(m_s3) && !ready;
    stall  = (m_fill_left > 0) || hold;
    dep_wr = m_writes(m_s3);
    e.s2    = m_s2;
    e.s3    = m_s3;
    e.bub   = m_bub;
    e.wen   = dep_wr && !hold && !rs;
    e.stall = stall;
    e.redir = redir && !stall;
    e.sel1  = (dep_wr && m_rs1(m_s2) && m_s2[19:15] == m_s3[11:7]) ? 2'b01 : 2'b10;
    e.sel2  = (dep_wr && m_rs2(m_s2) && m_s2[24:20] == m_s3[11:7]) ? 2'b01 : 2'b10;
    e.byp1  = dep_wr && m_rs1(ins) && ins[19:15] == m_s3[11:7];
    e.byp2  = dep_wr && m_rs2(ins) && ins[24:20] == m_s3[11:7];
    e.comb  = !rs;
    exp_q.push_back(e);
  endtask

  task automatic model_advance(input logic [31:0] ins, input bit redir, input bit ready,
                               input bit rs);
    bit hold;
    bit stall;
    if (rs) begin
      m_s2 = NOP; m_s3 = NOP; m_bub = 32'd0; m_fill_left = FILL; m_valid = 1'b1;
    end else if (m_valid) begin
      hold  = m_mem(m_s3) && !ready;
      stall = (m_fill_left > 0) || hold;
      if (stall || redir) m_bub = m_bub + 32'd1;
      if (m_fill_left > 0) begin
        m_s3 = m_s2; m_s2 = NOP; m_fill_left--;
      end else if (!hold) begin
        m_s3 = m_s2; m_s2 = redir ? NOP : ins;
      end
    end
  endtask

  // One clock of stimulus: drive, predict, clock, update the model.
  task automatic step(input logic [31:0] ins, input bit redir, input bit ready, input bit rs);
    instruction_s1 = ins;
    redirect_s2    = redir;
    dmem_ready     = ready;
    rst            = rs;
    if (m_valid) push_expect(ins, redir, ready, rs);
    @(posedge clk);
    #1;
    model_advance(ins, redir, ready, rs);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("instruction_s2", instruction_s2, mon_e.s2);
      check("instruction_s3", instruction_s3, mon_e.s3);
      check("bubble_cnt", bubble_cnt, mon_e.bub);
      check("s3_wen", {31'd0, s3_wen}, {31'd0, mon_e.wen});
      if (mon_e.comb) begin
        check("pc_stall", {31'd0, pc_stall}, {31'd0, mon_e.stall});
        check("pc_redirect", {31'd0, pc_redirect}, {31'd0, mon_e.redir});
        check("rs1_sel", {30'd0, rs1_sel}, {30'd0, mon_e.sel1});
        check("rs2_sel", {30'd0, rs2_sel}, {30'd0, mon_e.sel2});
        check("rf_bypass1", {31'd0, rf_bypass1}, {31'd0, mon_e.byp1});
        check("rf_bypass2", {31'd0, rf_bypass2}, {31'd0, mon_e.byp2});
      end
    end
  end

  initial begin
    // Reset fill
    step(NOP, 1'b0, 1'b1, 1'b1);
    step(NOP, 1'b0, 1'b1, 1'b1);
    step(NOP, 1'b0, 1'b1, 1'b0);          // FILL cycle
    // Back-to-back RAW, non-dependent, and x0 destination
    step(ADDI_X5_7, 1'b0, 1'b1, 1'b0);
    step(ADD_X6_X5, 1'b0, 1'b1, 1'b0);
    step(ADD_X6_X0, 1'b0, 1'b1, 1'b0);
    step(ADDI_X0_1, 1'b0, 1'b1, 1'b0);
    step(ADD_X6_X0, 1'b0, 1'b1, 1'b0);
    step(NOP, 1'b0, 1'b1, 1'b0);
    // Taken branch
    step(BEQ_X1_X2, 1'b0, 1'b1, 1'b0);
    step(ADDI_X5_7, 1'b1, 1'b1, 1'b0);
    step(NOP, 1'b0, 1'b1, 1'b0);
    // Load stall, 3 cycles, dependent instruction behind it
    step(LW_X7, 1'b0, 1'b1, 1'b0);
    step(ADD_X8_X7, 1'b0, 1'b1, 1'b0);
    repeat (3) step(NOP, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b1, 1'b0);
    step(NOP, 1'b0, 1'b1, 1'b0);
    // Store stall with a pending redirect
    step(SW_X2, 1'b0, 1'b1, 1'b0);
    step(BEQ_X1_X2, 1'b0, 1'b1, 1'b0);
    repeat (2) step(ADDI_X5_7, 1'b1, 1'b0, 1'b0);
    step(ADDI_X5_7, 1'b1, 1'b1, 1'b0);
    step(NOP, 1'b0, 1'b1, 1'b0);
    // Reset while in MEM_WAIT
    step(LW_X7, 1'b0, 1'b1, 1'b0);
    step(NOP, 1'b0, 1'b1, 1'b0);
    repeat (2) step(NOP, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b1);
    step(NOP, 1'b0, 1'b1, 1'b0);
    step(NOP, 1'b0, 1'b1, 1'b0);
    // Random traffic with hazard-dense register numbers
    for (int n = 0; n < 3000; n++) begin
      step(rand_instr(),
           $urandom_range(4, 0) == 0,
           $urandom_range(2, 0) != 0,
           $urandom_range(99, 0) == 0);
    end
    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencing controller for the 3-stage RV32I core: s1 fetch/decode, s2 execute, s3 memory/writeback. It owns the s2 and s3 instruction registers and injects NOPs on reset fill and on taken control flow. It also freezes the pipeline while the data memory is not ready, and drives the operand-forwarding and regfile-bypass selects consumed by s1/s2 decode and the ALU muxes. All per-stage control decode (s2_control and peers) reads `instruction_s2`/`instruction_s3` from this block.

## Interface
- `FILL_CYCLES`, default 1: cycles after reset before `instruction_s1` is valid (IMEM read latency).
- `NOP`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk` in 1: core clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `instruction_s1` in 32: IMEM output for the current s1 slot.
- `redirect_s2` in 1: s2 resolved a taken branch, JAL or JALR this cycle.
- `dmem_ready` in 1: data memory has completed the s3 load/store this cycle.
- `instruction_s2` out 32: registered s2 instruction.
- `instruction_s3` out 32: registered s3 instruction.
- `pc_stall` out 1: hold PC and the IMEM address.
- `pc_redirect` out 1: PC takes the s2 target this cycle.
- `rs1_sel`, `rs2_sel` out 2: s2 operand source. 2'b10 is the regfile/s2 pipeline register; 2'b01 is s3 writeback data; 2'b00 is never driven.
- `rf_bypass1`, `rf_bypass2` out 1: s1 regfile read returns s3 writeback data (write-through).
- `s3_wen` out 1: regfile write enable for s3 rd.
- `bubble_cnt` out 32: count of cycles spent in fill, flush or stall.

## Operation
- **Decode helpers (internal):**
  - `writes_rd(i)` is true for LUI, AUIPC, JAL, JALR, LOAD, ARI_RTYPE, ARI_ITYPE and CSR, and only when rd != 0.
  - `uses_rs1(i)` is true for JALR, BRANCH, LOAD, STORE, ARI_RTYPE, ARI_ITYPE and CSR with func3 = 001. It is false for func3 = 101 (csrrwi).
  - `uses_rs2(i)` is true for BRANCH, STORE and ARI_RTYPE.
  - `is_mem(i)` is true for LOAD and STORE.
- **FSM states:** FILL, RUN, MEM_WAIT.
  - **FILL:**
    - Entered on reset. A counter loads FILL_CYCLES-1.
    - Outputs: `pc_stall`=1; NOP is clocked into s2; s3 advances normally.
    - Transitions to RUN after FILL_CYCLES cycles.
  - **RUN:**
    - s3 <= s2 every cycle.
    - s2 <= NOP if `redirect_s2`, else s2 <= `instruction_s1`.
    - `pc_redirect` = `redirect_s2`.
    - If `is_mem(s3)` && !`dmem_ready`, the FSM enters MEM_WAIT. In that same cycle s2/s3 hold, `pc_stall`=1, and `pc_redirect` is forced 0.
  - **MEM_WAIT:**
    - s2, s3 and PC are held, and `redirect_s2` is ignored.
    - On `dmem_ready`=1 the FSM returns to RUN. That cycle behaves exactly like a RUN cycle (advance, honor `redirect_s2`).
- **Stall definition:** stall = (state==FILL) || (`is_mem(s3)` && !`dmem_ready`). This signal is combinational and also covers the cycle in which the FSM enters MEM_WAIT.
- **Forwarding to s2:**
  - `rs1_sel` = 2'b01 iff `writes_rd(s3)` && `uses_rs1(s2)` && rs1(s2)==rd(s3); otherwise 2'b10.
  - `rs2_sel` uses the same rule with rs2.
- **Bypass to s1:**
  - `rf_bypass1` = `writes_rd(s3)` && rs1(`instruction_s1`)==rd(s3) && `uses_rs1(instruction_s1)`.
  - `rf_bypass2` uses the same rule with rs2.
- **Writeback enable:** `s3_wen` = `writes_rd(s3)` && !(`is_mem(s3)` && !`dmem_ready`). As a result a stalled load writes exactly once, on its ready cycle.
- **Priority:** rst > stall > redirect > normal advance.
- **`bubble_cnt`:**
  - Increments by 1 on any cycle with stall=1, or with `redirect_s2`=1 while not stalled.
  - Wraps modulo 2^32 and clears on reset.

## Timing
- **Reset values:**
  - `instruction_s2` = `instruction_s3` = NOP; state = FILL; `bubble_cnt` = 0.
  - Because s2/s3 hold NOP: `pc_stall`=1, `pc_redirect`=0, `rs1_sel`=`rs2_sel`=2'b10, `rf_bypass1`=`rf_bypass2`=0, `s3_wen`=0.
- **Register timing:** `instruction_s2`, `instruction_s3`, state and `bubble_cnt` update on the rising edge only.
- **Combinational outputs:** `pc_stall`, `pc_redirect`, `rs1_sel`, `rs2_sel`, `rf_bypass1`, `rf_bypass2` and `s3_wen` are combinational from the registers plus the inputs. No combinational path exists from `redirect_s2` to the sel/bypass outputs.
- **Taken redirect:** costs exactly 1 bubble in s2.
- **Memory stall:** N cycles of `dmem_ready`=0 cost exactly N stall cycles.
- **Reset asserted mid-MEM_WAIT:** the next state is FILL, the in-flight s3 instruction is discarded, and no `s3_wen` occurs.
- **Redirect during stall:** a redirect asserted during a stall is not lost. s2 is held, so `redirect_s2` re-presents on the release cycle.
- **x0 destinations:** rd=x0 never forwards, bypasses or writes.

## Test plan
- **Reset fill:** rst high 2 cycles, then low with FILL_CYCLES=1 -> `pc_stall`=1 for 1 cycle, `instruction_s2`=NOP, then `instruction_s2` follows `instruction_s1`; `bubble_cnt`=1.
- **Back-to-back RAW:** `addi x5,x0,7` then `add x6,x5,x5` -> the cycle the add is in s2 has `rs1_sel`=`rs2_sel`=2'b01. An `add x6,x0,x0` gives 2'b10, and `addi x0,x0,1` followed by `add x6,x0,x0` never forwards.
- **Taken branch:** `beq` with `redirect_s2`=1 -> `pc_redirect`=1 that cycle, `instruction_s2`=NOP next cycle, `bubble_cnt`+1.
- **Load stall:** `lw x7` in s3 with `dmem_ready` low 3 cycles -> s2/s3 frozen for 3 cycles with `s3_wen`=0, then a single `s3_wen`=1 pulse on the ready cycle; a dependent s2 instruction gets `rs1_sel`=2'b01; `bubble_cnt`+3.
- **Stall plus redirect:** `redirect_s2`=1 while s3 is a store with `dmem_ready`=0 for 2 cycles -> `pc_redirect`=0 for those 2 cycles; on the release cycle `pc_redirect`=1 and NOP enters s2.
- **Reset in MEM_WAIT:** rst pulse during MEM_WAIT -> state FILL, both instruction registers NOP, `s3_wen` never asserted for the killed load.
